// File: rtl/soc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_pkg
//  Description : Shared encodings for the SoC memory arbiter (FSM states and
//                grant identifiers).
//  Revision    : 1.0 - initial release
// ============================================================================
package soc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage : soc_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Round-robin arbiter sharing one fixed-latency single-port RAM
//                between the CPU fetch port and the CPU load/store port.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import soc_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_valid,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_ready,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_valid,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic                  d_ready,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  m_en,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic [DATA_W-1:0]     m_rdata
);

    localparam int         c_strb_w   = DATA_W / 8;
    localparam logic [1:0] c_cnt_init = 2'(MEM_LAT - 1);

    state_t                r_state,      w_state_nx;
    logic [1:0]            r_cnt,        w_cnt_nx;
    logic                  r_last_grant, w_last_nx;
    logic                  r_gnt,        w_gnt_nx;
    logic                  r_m_en,       w_m_en_nx;
    logic [ADDR_W-1:0]     r_m_addr,     w_m_addr_nx;
    logic [DATA_W-1:0]     r_m_wdata,    w_m_wdata_nx;
    logic [c_strb_w-1:0]   r_m_wstrb,    w_m_wstrb_nx;
    logic                  w_gnt_sel;
    logic                  w_done;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 2'd0;
            r_last_grant <= GNT_I;
            r_gnt        <= GNT_I;
            r_m_en       <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_m_wstrb    <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_last_grant <= w_last_nx;
            r_gnt        <= w_gnt_nx;
            r_m_en       <= w_m_en_nx;
            r_m_addr     <= w_m_addr_nx;
            r_m_wdata    <= w_m_wdata_nx;
            r_m_wstrb    <= w_m_wstrb_nx;
        end
    end

    // Strobes default low so m_en/m_wstrb are high only during ISSUE.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_last_nx    = r_last_grant;
        w_gnt_nx     = r_gnt;
        w_m_en_nx    = 1'b0;
        w_m_addr_nx  = r_m_addr;
        w_m_wdata_nx = r_m_wdata;
        w_m_wstrb_nx = '0;
        w_gnt_sel    = GNT_I;

        case (r_state)
            ST_IDLE: begin
                if (i_valid || d_valid) begin
                    if (i_valid && d_valid) begin
                        w_gnt_sel = ~r_last_grant;
                        w_last_nx = w_gnt_sel;
                    end else begin
                        w_gnt_sel = d_valid ? GNT_D : GNT_I;
                    end
                    w_gnt_nx  = w_gnt_sel;
                    w_m_en_nx = 1'b1;
                    if (w_gnt_sel == GNT_D) begin
                        w_m_addr_nx  = d_addr;
                        w_m_wdata_nx = d_wdata;
                        w_m_wstrb_nx = d_wstrb;
                    end else begin
                        w_m_addr_nx  = i_addr;
                    end
                    w_state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_cnt_nx   = c_cnt_init;
                w_state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - 2'd1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign w_done  = (r_state == ST_WAIT) && (r_cnt == 2'd0);
    assign i_ready = w_done && (r_gnt == GNT_I);
    assign d_ready = w_done && (r_gnt == GNT_D);
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    assign m_en    = r_m_en;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign m_wstrb = r_m_wstrb;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/mem_model.sv
`default_nettype none
// ============================================================================
//  Module      : mem_model
//  Description : Behavioural single-port RAM with configurable read latency,
//                byte-strobed writes and a backdoor preload port.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_model #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                en,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    input  logic                pl_en,
    input  logic [ADDR_W-1:0]   pl_addr,
    input  logic [DATA_W-1:0]   pl_data
);

    logic [DATA_W-1:0] mem  [256];
    logic [DATA_W-1:0] pipe [MEM_LAT];

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr[9:2]] <= pl_data;
        end
        if (en) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wstrb[b]) begin
                    mem[addr[9:2]][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        pipe[0] <= mem[addr[9:2]];
        for (int k = 1; k < MEM_LAT; k++) begin
            pipe[k] <= pipe[k-1];
        end
    end

    assign rdata = pipe[MEM_LAT-1];

endmodule : mem_model
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Scoreboard bench for mem_arbiter with MEM_LAT=1 and MEM_LAT=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import soc_pkg::*;

    typedef struct {
        int          inst;
        logic        port;
        logic [31:0] data;
        logic        chk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1_n, i1_valid, d1_valid, i1_ready, d1_ready, m1_en, pl1_en;
    logic [31:0] i1_addr, d1_addr, d1_wdata, i1_rdata, d1_rdata;
    logic [31:0] m1_addr, m1_wdata, m1_rdata, pl1_addr, pl1_data;
    logic [3:0]  d1_wstrb, m1_wstrb;

    logic        rst3_n, i3_valid, d3_valid, i3_ready, d3_ready, m3_en, pl3_en;
    logic [31:0] i3_addr, d3_addr, d3_wdata, i3_rdata, d3_rdata;
    logic [31:0] m3_addr, m3_wdata, m3_rdata, pl3_addr, pl3_data;
    logic [3:0]  d3_wstrb, m3_wstrb;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .resetn(rst1_n),
        .i_valid(i1_valid), .i_addr(i1_addr), .i_ready(i1_ready), .i_rdata(i1_rdata),
        .d_valid(d1_valid), .d_addr(d1_addr), .d_wdata(d1_wdata), .d_wstrb(d1_wstrb),
        .d_ready(d1_ready), .d_rdata(d1_rdata),
        .m_en(m1_en), .m_addr(m1_addr), .m_wdata(m1_wdata), .m_wstrb(m1_wstrb),
        .m_rdata(m1_rdata)
    );
    mem_model #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_mem1 (
        .clk(clk), .en(m1_en), .addr(m1_addr), .wdata(m1_wdata), .wstrb(m1_wstrb),
        .rdata(m1_rdata), .pl_en(pl1_en), .pl_addr(pl1_addr), .pl_data(pl1_data)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .resetn(rst3_n),
        .i_valid(i3_valid), .i_addr(i3_addr), .i_ready(i3_ready), .i_rdata(i3_rdata),
        .d_valid(d3_valid), .d_addr(d3_addr), .d_wdata(d3_wdata), .d_wstrb(d3_wstrb),
        .d_ready(d3_ready), .d_rdata(d3_rdata),
        .m_en(m3_en), .m_addr(m3_addr), .m_wdata(m3_wdata), .m_wstrb(m3_wstrb),
        .m_rdata(m3_rdata)
    );
    mem_model #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_mem3 (
        .clk(clk), .en(m3_en), .addr(m3_addr), .wdata(m3_wdata), .wstrb(m3_wstrb),
        .rdata(m3_rdata), .pl_en(pl3_en), .pl_addr(pl3_addr), .pl_data(pl3_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every completion pops the oldest expectation.
    task automatic sb_check(input int inst, input logic port, input logic [31:0] data);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_ready: got inst=%0d port=%0d expected no completion at %0t",
                     inst, port, $time);
        end else begin
            e = sb.pop_front();
            if (e.inst != inst || e.port != port || (e.chk && e.data !== data)) begin
                errors++;
                $display("FAIL sb_completion: got inst=%0d port=%0d data=0x%08h expected inst=%0d port=%0d data=0x%08h at %0t",
                         inst, port, data, e.inst, e.port, e.data, $time);
            end
        end
    endtask

    always @(negedge clk) begin
        if (i1_ready) sb_check(0, GNT_I, i1_rdata);
        if (d1_ready) sb_check(0, GNT_D, d1_rdata);
        if (i3_ready) sb_check(1, GNT_I, i3_rdata);
        if (d3_ready) sb_check(1, GNT_D, d3_rdata);
    end

    task automatic preload(input int inst, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        if (inst == 0) begin pl1_en = 1'b1; pl1_addr = a; pl1_data = d; end
        else           begin pl3_en = 1'b1; pl3_addr = a; pl3_data = d; end
        @(negedge clk);
        pl1_en = 1'b0;
        pl3_en = 1'b0;
    endtask

    task automatic push(input int inst, input logic port, input logic [31:0] d, input logic chk);
        exp_t e;
        e.inst = inst; e.port = port; e.data = d; e.chk = chk;
        sb.push_back(e);
    endtask

    // One isolated request; checks issue-cycle fields, latency and strobe count.
    task automatic single_req(input int inst, input logic port, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb,
                              input logic [31:0] exp_data, input logic chk, input int exp_lat);
        int   n;
        int   en_cnt;
        logic done;
        logic rdy;
        @(negedge clk);
        if (inst == 0) begin
            if (port) begin d1_valid = 1'b1; d1_addr = addr; d1_wdata = wdata; d1_wstrb = wstrb; end
            else      begin i1_valid = 1'b1; i1_addr = addr; end
        end else begin
            if (port) begin d3_valid = 1'b1; d3_addr = addr; d3_wdata = wdata; d3_wstrb = wstrb; end
            else      begin i3_valid = 1'b1; i3_addr = addr; end
        end
        push(inst, port, exp_data, chk);
        n = 0; en_cnt = 0; done = 1'b0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
            if ((inst == 0) ? m1_en : m3_en) en_cnt++;
            if (n == 1) begin
                check("issue_addr", (inst == 0) ? m1_addr : m3_addr, addr);
                check("issue_wstrb", 32'((inst == 0) ? m1_wstrb : m3_wstrb), port ? 32'(wstrb) : 32'd0);
            end
            rdy = port ? ((inst == 0) ? d1_ready : d3_ready) : ((inst == 0) ? i1_ready : i3_ready);
            if (rdy) done = 1'b1;
        end
        i1_valid = 1'b0; d1_valid = 1'b0; i3_valid = 1'b0; d3_valid = 1'b0;
        check("req_done", 32'(done), 32'd1);
        check("req_latency", n, exp_lat);
        check("m_en_cycles", en_cnt, 1);
    endtask

    task automatic reset_dut1();
        @(negedge clk); rst1_n = 1'b0;
        @(negedge clk);
        @(negedge clk); rst1_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int got;
        int last;
        logic first_port;

        rst1_n = 1'b0; rst3_n = 1'b0;
        i1_valid = 1'b0; d1_valid = 1'b0; i1_addr = '0; d1_addr = '0; d1_wdata = '0; d1_wstrb = '0;
        i3_valid = 1'b0; d3_valid = 1'b0; i3_addr = '0; d3_addr = '0; d3_wdata = '0; d3_wstrb = '0;
        pl1_en = 1'b0; pl1_addr = '0; pl1_data = '0;
        pl3_en = 1'b0; pl3_addr = '0; pl3_data = '0;
        repeat (3) @(negedge clk);

        check("rst_outputs1", {29'd0, m1_en, i1_ready, d1_ready}, 32'd0);
        check("rst_m_addr1", m1_addr, 32'd0);
        check("rst_m_wdata1", m1_wdata, 32'd0);
        check("rst_m_wstrb1", 32'(m1_wstrb), 32'd0);
        check("rst_outputs3", {28'd0, m3_wstrb}, 32'd0);
        rst1_n = 1'b1; rst3_n = 1'b1;

        preload(0, 32'h10, 32'h0050_0093);
        preload(0, 32'h20, 32'h1122_3344);
        preload(0, 32'h24, 32'h0000_0000);
        preload(0, 32'h30, 32'hDEAD_BEEF);
        preload(1, 32'h40, 32'hCAFE_F00D);
        preload(1, 32'h44, 32'h1357_9BDF);

        // Single fetch, MEM_LAT=1
        single_req(0, GNT_I, 32'h10, 32'h0, 4'h0, 32'h0050_0093, 1'b1, 2);

        // Byte write then read back
        single_req(0, GNT_D, 32'h20, 32'h0000_AB00, 4'b0010, 32'h0, 1'b0, 2);
        single_req(0, GNT_D, 32'h20, 32'h0, 4'b0000, 32'h1122_AB44, 1'b1, 2);
        single_req(0, GNT_D, 32'h24, 32'hA5A5_A5A5, 4'b1111, 32'h0, 1'b0, 2);
        single_req(0, GNT_D, 32'h24, 32'h11FF_FF22, 4'b1001, 32'h0, 1'b0, 2);
        single_req(0, GNT_I, 32'h24, 32'h0, 4'h0, 32'h11A5_A522, 1'b1, 2);

        // Continuous contention from reset: D, I, D, I, three cycles apart
        reset_dut1();
        @(negedge clk);
        i1_valid = 1'b1; i1_addr = 32'h10;
        d1_valid = 1'b1; d1_addr = 32'h30; d1_wstrb = 4'h0;
        push(0, GNT_D, 32'hDEAD_BEEF, 1'b1);
        push(0, GNT_I, 32'h0050_0093, 1'b1);
        push(0, GNT_D, 32'hDEAD_BEEF, 1'b1);
        push(0, GNT_I, 32'h0050_0093, 1'b1);
        got = 0; last = 0; n = 0;
        while (got < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (i1_ready || d1_ready) begin
                got++;
                check("contention_gap", n - last, (got == 1) ? 2 : 3);
                last = n;
            end
        end
        i1_valid = 1'b0; d1_valid = 1'b0;
        check("contention_count", got, 4);

        // MEM_LAT=3 data read
        single_req(1, GNT_D, 32'h40, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1, 4);

        // Reset during WAIT drops the completion
        @(negedge clk);
        d3_valid = 1'b1; d3_addr = 32'h40; d3_wstrb = 4'h0;
        @(negedge clk);
        check("rstwait_issue", 32'(m3_en), 32'd1);
        d3_valid = 1'b0;
        @(negedge clk);
        rst3_n = 1'b0;
        @(negedge clk);
        rst3_n = 1'b1;
        check("rstwait_state", 32'(u_dut3.r_state), 32'(ST_IDLE));
        repeat (6) begin
            check("rstwait_quiet", {29'd0, m3_en, i3_ready, d3_ready}, 32'd0);
            @(negedge clk);
        end

        // First conflict after reset goes to D
        i3_valid = 1'b1; i3_addr = 32'h44;
        d3_valid = 1'b1; d3_addr = 32'h40; d3_wstrb = 4'h0;
        push(1, GNT_D, 32'hCAFE_F00D, 1'b1);
        push(1, GNT_I, 32'h1357_9BDF, 1'b1);
        got = 0; n = 0; first_port = 1'b0;
        while (got < 2 && n < 40) begin
            @(negedge clk);
            n++;
            if (i3_ready || d3_ready) begin
                if (got == 0) first_port = d3_ready;
                got++;
            end
            if (d3_ready) d3_valid = 1'b0;
            if (i3_ready) i3_valid = 1'b0;
        end
        i3_valid = 1'b0; d3_valid = 1'b0;
        check("post_reset_first_gnt", 32'(first_port), 32'(GNT_D));
        check("post_reset_count", got, 2);

        // Idle bus
        repeat (20) begin
            @(negedge clk);
            check("idle_bus", {24'd0, m1_en, m1_wstrb, i1_ready, d1_ready, 1'b0}, 32'd0);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
